circuit_sweep_seq: RTL and testbench

Sequencer that sits directly upstream of the 16-bit, 2-bit-select combinational unit `circuitI` and also collects what that unit produces. It accepts one operand pair over a valid/ready handshake, holds the pair on the unit's A/B inputs, and steps the select through all four codes. After a programmable settle time per code, it samples the unit's output and emits one tagged result per code over a second valid/ready handshake. This replaces open-loop select stepping with a cycle-accurate, back-pressured sweep.

---
 rtl/circuit_sweep_seq_pkg.sv | 20 ++
 rtl/circuit_sweep_seq_if.sv | 28 ++
 rtl/circuit_sweep_seq_step_timer.sv | 28 ++
 rtl/circuit_sweep_seq.sv | 118 +++++++++++
 tb/tb_circuit_sweep_seq.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/circuit_sweep_seq_pkg.sv
// Shared types and helpers for the select-sweep sequencer that drives circuitI.
// The select ordering lives here so every user agrees on the k -> sel mapping.
package circuit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int STEP_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        EMIT,
        DONE
    } sweep_state_t;

    // Step index k maps to select with its two bits swapped: 0, 2, 1, 3.
    function automatic logic [1:0] sel_of_step(input logic [1:0] k);
        return {k[0], k[1]};
    endfunction

endpackage

// File: rtl/circuit_sweep_seq_if.sv
// Operand-in and result-out channels of the sweep sequencer.
// Both channels: a transfer happens on a rising clk edge where valid && ready; the
// sender holds valid and its payload steady until that edge, and ready never waits on valid.
interface circuit_sweep_seq_if
    import circuit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_sel;
    logic [WIDTH-1:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_sel, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_sel, res_data
    );
endinterface

// File: rtl/circuit_sweep_seq_step_timer.sv
// Loadable down-counter used to hold each select code for a fixed settle time.
// It stops at zero rather than wrapping, so a stalled owner cannot make it roll over.
module step_timer
    import circuit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [STEP_W-1:0] load_val,
    output logic              zero
);

    logic [STEP_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/circuit_sweep_seq.sv
// Sweeps the circuitI select through all four codes for one operand pair,
// sampling the unit after a settle time and emitting one tagged result per code.
module circuit_sweep_seq
    import circuit_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int STEP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    circuit_sweep_seq_if.slave   bus,
    input  logic                 flush,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    output logic [1:0]           sel,
    input  logic [WIDTH-1:0]     unit_out,
    output logic                 busy,
    output logic                 done,
    output sweep_state_t         dbg_state
);

    localparam logic [STEP_W-1:0] HOLD_LOAD = STEP_W'(STEP_CYCLES - 1);

    sweep_state_t     state;
    logic [1:0]       k;
    logic             res_valid;
    logic [1:0]       res_sel;
    logic [WIDTH-1:0] res_data;

    logic accept;
    logic res_fire;
    logic last_step;
    logic timer_load;
    logic timer_en;
    logic timer_zero;

    assign accept     = (state == IDLE) && bus.in_valid && !flush;
    assign res_fire   = (state == EMIT) && bus.res_ready && !flush;
    assign last_step  = (k == 2'd3);
    assign timer_load = accept || (res_fire && !last_step);
    // The timer only runs while a code is being driven, so back-pressure freezes it.
    assign timer_en   = (state == DRIVE) && !flush;

    step_timer u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (HOLD_LOAD),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= 2'd0;
            op_a      <= '0;
            op_b      <= '0;
            sel       <= 2'd0;
            res_valid <= 1'b0;
            res_sel   <= 2'd0;
            res_data  <= '0;
            done      <= 1'b0;
        end else if (flush) begin
            // Operands and select are left as-is; only the sweep bookkeeping is dropped.
            state     <= IDLE;
            k         <= 2'd0;
            res_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_a  <= bus.in_a;
                        op_b  <= bus.in_b;
                        k     <= 2'd0;
                        sel   <= sel_of_step(2'd0);
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (timer_zero) begin
                        res_data  <= unit_out;
                        res_sel   <= sel;
                        res_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        if (last_step) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            k     <= k + 2'd1;
                            sel   <= sel_of_step(k + 2'd1);
                            state <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = res_valid;
    assign bus.res_sel   = res_sel;
    assign bus.res_data  = res_data;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_circuit_sweep_seq.sv
// Bench for circuit_sweep_seq: one instance with a combinational unit (settle 1)
// and one with a unit whose output lags two cycles (settle 3).
module tb_circuit_sweep_seq;
    import circuit_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_v     [2];
    logic         in_valid_v  [2];
    logic         res_ready_v [2];
    logic         flush_v     [2];
    logic [W-1:0] in_a_v      [2];
    logic [W-1:0] in_b_v      [2];

    wire          in_ready_v  [2];
    wire          res_valid_v [2];
    wire          busy_v      [2];
    wire          done_v      [2];
    wire [1:0]    res_sel_v   [2];
    wire [1:0]    sel_v       [2];
    wire [1:0]    dbg_v       [2];
    wire [W-1:0]  res_data_v  [2];
    wire [W-1:0]  op_a_v      [2];
    wire [W-1:0]  op_b_v      [2];
    wire [W-1:0]  unit_out_v  [2];

    // Stand-in behaviour for circuitI.
    function automatic logic [W-1:0] unit_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] s);
        case (s)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int S = (g == 0) ? 1 : 3;
        circuit_sweep_seq_if #(.WIDTH(W)) bus ();

        assign bus.in_valid    = in_valid_v[g];
        assign bus.in_a        = in_a_v[g];
        assign bus.in_b        = in_b_v[g];
        assign bus.res_ready   = res_ready_v[g];
        assign in_ready_v[g]   = bus.in_ready;
        assign res_valid_v[g]  = bus.res_valid;
        assign res_sel_v[g]    = bus.res_sel;
        assign res_data_v[g]   = bus.res_data;

        if (g == 0) begin : comb_unit
            assign unit_out_v[g] = unit_fn(op_a_v[g], op_b_v[g], sel_v[g]);
        end else begin : slow_unit
            logic [W-1:0] d1, d2;
            always @(posedge clk) begin
                d1 <= unit_fn(op_a_v[g], op_b_v[g], sel_v[g]);
                d2 <= d1;
            end
            assign unit_out_v[g] = d2;
        end

        circuit_sweep_seq #(.WIDTH(W), .STEP_CYCLES(S)) dut (
            .clk       (clk),
            .rst_n     (rst_n_v[g]),
            .bus       (bus),
            .flush     (flush_v[g]),
            .op_a      (op_a_v[g]),
            .op_b      (op_b_v[g]),
            .sel       (sel_v[g]),
            .unit_out  (unit_out_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .dbg_state (dbg_v[g])
        );
    end

    // Cycle count, accepted operand pairs and done pulses per instance.
    int cyc = 0;
    int acc_cnt  [2] = '{0, 0};
    int last_acc [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int exp_done [2] = '{0, 0};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int g = 0; g < 2; g++) begin
            if (rst_n_v[g] && in_valid_v[g] && in_ready_v[g] && !flush_v[g]) begin
                acc_cnt[g]  <= acc_cnt[g] + 1;
                last_acc[g] <= cyc + 1;
            end
            if (done_v[g]) done_cnt[g] <= done_cnt[g] + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int order [4] = '{0, 2, 1, 3};
    logic [W+1:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int g, output int at);
        int n;
        n = 0;
        while (!res_valid_v[g] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_seen", res_valid_v[g], 1);
        at = cyc;
    endtask

    // abort_kind: 0 none, 1 flush in EMIT of abort_k, 2 reset in DRIVE of abort_k.
    task automatic run_sweep(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int stall_k, input int stall_n, input bit eager,
                             input int abort_kind, input int abort_k);
        int s, t0, h, rise;
        logic [W+1:0] e;
        s = (g == 0) ? 1 : 3;
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            exp_q.push_back({2'(order[k]), unit_fn(a, b, 2'(order[k]))});

        in_a_v[g] = a;
        in_b_v[g] = b;
        in_valid_v[g] = 1'b1;
        chk($sformatf("g%0d in_ready_idle", g), in_ready_v[g], 1);
        @(negedge clk);
        t0 = cyc;
        in_valid_v[g] = 1'b0;
        chk($sformatf("g%0d op_a", g), op_a_v[g], a);
        chk($sformatf("g%0d op_b", g), op_b_v[g], b);
        chk($sformatf("g%0d sel_start", g), sel_v[g], 0);
        chk($sformatf("g%0d busy", g), busy_v[g], 1);
        chk($sformatf("g%0d in_ready_busy", g), in_ready_v[g], 0);

        h = t0;
        res_ready_v[g] = eager;
        for (int k = 0; k < 4; k++) begin
            if (abort_kind == 2 && k == abort_k) begin
                rst_n_v[g] = 1'b0;
                #1;
                chk($sformatf("g%0d rst_op_a", g), op_a_v[g], 0);
                chk($sformatf("g%0d rst_op_b", g), op_b_v[g], 0);
                chk($sformatf("g%0d rst_sel", g), sel_v[g], 0);
                chk($sformatf("g%0d rst_res_valid", g), res_valid_v[g], 0);
                chk($sformatf("g%0d rst_res_data", g), res_data_v[g], 0);
                chk($sformatf("g%0d rst_res_sel", g), res_sel_v[g], 0);
                chk($sformatf("g%0d rst_done", g), done_v[g], 0);
                chk($sformatf("g%0d rst_busy", g), busy_v[g], 0);
                res_ready_v[g] = 1'b0;
                @(negedge clk);
                rst_n_v[g] = 1'b1;
                @(negedge clk);
                chk($sformatf("g%0d rst_in_ready", g), in_ready_v[g], 1);
                return;
            end
            wait_valid(g, rise);
            chk($sformatf("g%0d rise_gap_k%0d", g, k), rise - h, s);
            e = exp_q.pop_front();
            chk($sformatf("g%0d res_sel_k%0d", g, k), res_sel_v[g], e[W+1:W]);
            chk($sformatf("g%0d res_data_k%0d", g, k), res_data_v[g], e[W-1:0]);
            chk($sformatf("g%0d sel_k%0d", g, k), sel_v[g], e[W+1:W]);
            if (abort_kind == 1 && k == abort_k) begin
                flush_v[g] = 1'b1;
                in_valid_v[g] = 1'b1;
                in_a_v[g] = ~a;
                in_b_v[g] = ~b;
                res_ready_v[g] = 1'b0;
                @(negedge clk);
                flush_v[g] = 1'b0;
                in_valid_v[g] = 1'b0;
                chk($sformatf("g%0d flush_res_valid", g), res_valid_v[g], 0);
                chk($sformatf("g%0d flush_in_ready", g), in_ready_v[g], 1);
                chk($sformatf("g%0d flush_busy", g), busy_v[g], 0);
                chk($sformatf("g%0d flush_done", g), done_v[g], 0);
                chk($sformatf("g%0d flush_sel_kept", g), sel_v[g], e[W+1:W]);
                flush_v[g] = 1'b1;
                in_valid_v[g] = 1'b1;
                @(negedge clk);
                flush_v[g] = 1'b0;
                in_valid_v[g] = 1'b0;
                chk($sformatf("g%0d flush_no_accept", g), op_a_v[g], a);
                chk($sformatf("g%0d flush_idle", g), busy_v[g], 0);
                return;
            end
            if (k == stall_k) begin
                for (int n = 0; n < stall_n; n++) begin
                    @(negedge clk);
                    chk($sformatf("g%0d stall_valid", g), res_valid_v[g], 1);
                    chk($sformatf("g%0d stall_data", g), res_data_v[g], e[W-1:0]);
                    chk($sformatf("g%0d stall_res_sel", g), res_sel_v[g], e[W+1:W]);
                    chk($sformatf("g%0d stall_sel", g), sel_v[g], e[W+1:W]);
                end
            end
            res_ready_v[g] = 1'b1;
            @(negedge clk);
            h = cyc;
            res_ready_v[g] = eager;
            if (k < 3) chk($sformatf("g%0d valid_drop_k%0d", g, k), res_valid_v[g], 0);
        end
        chk($sformatf("g%0d done_pulse", g), done_v[g], 1);
        chk($sformatf("g%0d sweep_len", g), h - t0, 4 * (s + 1) + stall_n);
        chk($sformatf("g%0d done_in_ready", g), in_ready_v[g], 0);
        exp_done[g]++;
        res_ready_v[g] = 1'b0;
        @(negedge clk);
        chk($sformatf("g%0d done_low", g), done_v[g], 0);
        chk($sformatf("g%0d back_idle", g), in_ready_v[g], 1);
        chk($sformatf("g%0d end_busy", g), busy_v[g], 0);
        chk($sformatf("g%0d end_valid", g), res_valid_v[g], 0);
        chk($sformatf("g%0d end_op_a", g), op_a_v[g], a);
    endtask

    initial begin
        logic [W-1:0] a1, b1, a2, b2;
        int t0, hd, acc0, n;

        for (int g = 0; g < 2; g++) begin
            rst_n_v[g] = 1'b0;
            in_valid_v[g] = 1'b0;
            res_ready_v[g] = 1'b0;
            flush_v[g] = 1'b0;
            in_a_v[g] = '0;
            in_b_v[g] = '0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("g%0d reset_op_a", g), op_a_v[g], 0);
            chk($sformatf("g%0d reset_sel", g), sel_v[g], 0);
            chk($sformatf("g%0d reset_res_valid", g), res_valid_v[g], 0);
            chk($sformatf("g%0d reset_res_data", g), res_data_v[g], 0);
            chk($sformatf("g%0d reset_done", g), done_v[g], 0);
            chk($sformatf("g%0d reset_busy", g), busy_v[g], 0);
            chk($sformatf("g%0d reset_state", g), dbg_v[g], IDLE);
            rst_n_v[g] = 1'b1;
        end
        @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk($sformatf("g%0d release_in_ready", g), in_ready_v[g], 1);

        run_sweep(0, 16'd12, 16'd13, -1, 0, 1'b0, 0, 0);
        run_sweep(0, 16'd12, 16'd13, 1, 5, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++)
            run_sweep(0, 16'($urandom), 16'($urandom), -1, 0, 1'b1, 0, 0);

        run_sweep(1, 16'($urandom), 16'($urandom), -1, 0, 1'b0, 0, 0);
        run_sweep(1, 16'($urandom), 16'($urandom), $urandom_range(0, 3), $urandom_range(1, 6), 1'b0, 0, 0);
        run_sweep(1, 16'($urandom) | 16'h0101, 16'($urandom), -1, 0, 1'b0, 2, 2);
        run_sweep(1, 16'($urandom), 16'($urandom), -1, 0, 1'b1, 0, 0);

        run_sweep(0, 16'($urandom), 16'($urandom), -1, 0, 1'b0, 1, 1);
        run_sweep(0, 16'hFFFF, 16'h0001, -1, 0, 1'b0, 0, 0);

        // in_valid held high across a whole sweep.
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        a2 = ~a1;
        b2 = ~b1;
        acc0 = acc_cnt[0];
        in_a_v[0] = a1;
        in_b_v[0] = b1;
        in_valid_v[0] = 1'b1;
        res_ready_v[0] = 1'b1;
        @(negedge clk);
        t0 = cyc;
        in_a_v[0] = a2;
        in_b_v[0] = b2;
        chk("hold first_accept_op_a", op_a_v[0], a1);
        chk("hold first_accept_cnt", acc_cnt[0], acc0 + 1);
        n = 0;
        while (!done_v[0] && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("hold done_seen", done_v[0], 1);
        hd = cyc;
        exp_done[0]++;
        chk("hold sweep_len", hd - t0, 8);
        chk("hold single_accept", acc_cnt[0], acc0 + 1);
        chk("hold op_a_kept", op_a_v[0], a1);
        @(negedge clk);
        chk("hold in_ready_back", in_ready_v[0], 1);
        chk("hold op_a_before_second", op_a_v[0], a1);
        @(negedge clk);
        chk("hold second_op_a", op_a_v[0], a2);
        chk("hold second_op_b", op_b_v[0], b2);
        chk("hold second_accept_cnt", acc_cnt[0], acc0 + 2);
        chk("hold second_accept_cycle", last_acc[0], hd + 2);
        chk("hold second_busy", busy_v[0], 1);
        in_valid_v[0] = 1'b0;
        res_ready_v[0] = 1'b0;
        flush_v[0] = 1'b1;
        @(negedge clk);
        flush_v[0] = 1'b0;
        chk("hold flushed_idle", in_ready_v[0], 1);

        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++)
            chk($sformatf("g%0d done_count", g), done_cnt[g], exp_done[g]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
